// File: rtl/fine_channelizer_div_seq.sv
// Sequential signed 32/16 restoring divider with saturated quotient, valid/ready on both sides.
// Optional remainder output enabled by defining FINE_CHANNELIZER_DIV_REM_EN.
module fine_channelizer_div_seq #(
   parameter int DIVIDEND_WIDTH = 32,
   parameter int DIVISOR_WIDTH  = 16,
   parameter int QUOTIENT_WIDTH = 16
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      ce,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [DIVIDEND_WIDTH-1:0] dividend,
   input  logic [DIVISOR_WIDTH-1:0]  divisor,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [QUOTIENT_WIDTH-1:0] quotient,
   output logic [QUOTIENT_WIDTH-1:0] remainder,
   output logic                      ovf,
   output logic                      dbz,
   output logic [1:0]                dbg_state
);

   // Handshakes: a transfer completes on a rising edge where ce is high and both
   // valid and ready are high; valid never drops before its transfer completes.
   typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

   state_t      state_q, state_d;
   logic [31:0] dvd_q;
   logic [16:0] dvs_q;
   logic [31:0] prem_q;
   logic [5:0]  cnt_q;
   logic        neg_dvd_q;
   logic        neg_quo_q;
   logic        zdiv_q;
   logic [15:0] quot_q;
   logic        ovf_q;
   logic        dbz_q;

   logic        accept, iter, fin;
   logic [32:0] shifted;
   logic        ge;
   logic [31:0] prem_nxt;
   logic [31:0] dvd_abs;
   logic [16:0] dvs_abs;
   logic [15:0] quot_fin;
   logic        sat_fin;

   // ---------------- FSM ----------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (ce && in_valid)          state_d = CALC;
         CALC:    if (ce && cnt_q == 6'd32)    state_d = DONE;
         DONE:    if (ce && out_ready)         state_d = IDLE;
         default:                              state_d = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (state_q == IDLE);
      out_valid = (state_q == DONE);
      dbg_state = state_q;
   end

   // ---------------- datapath ----------------
   assign accept = ce && in_valid && in_ready;
   assign iter   = ce && (state_q == CALC) && (cnt_q != 6'd32);
   assign fin    = ce && (state_q == CALC) && (cnt_q == 6'd32);

   assign dvd_abs = dividend[31] ? (32'd0 - dividend) : dividend;
   assign dvs_abs = 17'd0 - {divisor[15], divisor};

   // One restoring step: partial remainder never exceeds the 17-bit divisor magnitude.
   assign shifted  = {prem_q, dvd_q[31]};
   assign ge       = (shifted >= {16'd0, dvs_q});
   assign prem_nxt = ge ? (shifted[31:0] - {15'd0, dvs_q}) : shifted[31:0];

   always_comb begin
      quot_fin = 16'd0;
      sat_fin  = 1'b0;
      if (zdiv_q) begin
         quot_fin = neg_dvd_q ? 16'h8000 : 16'h7FFF;
      end else if (neg_quo_q) begin
         if (dvd_q > 32'd32768) begin
            quot_fin = 16'h8000;
            sat_fin  = 1'b1;
         end else begin
            quot_fin = 16'd0 - dvd_q[15:0];
         end
      end else begin
         if (dvd_q > 32'd32767) begin
            quot_fin = 16'h7FFF;
            sat_fin  = 1'b1;
         end else begin
            quot_fin = dvd_q[15:0];
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         dvd_q     <= '0;
         dvs_q     <= '0;
         prem_q    <= '0;
         cnt_q     <= '0;
         neg_dvd_q <= 1'b0;
         neg_quo_q <= 1'b0;
         zdiv_q    <= 1'b0;
         quot_q    <= '0;
         ovf_q     <= 1'b0;
         dbz_q     <= 1'b0;
      end else if (accept) begin
         dvd_q     <= dvd_abs;
         dvs_q     <= divisor[15] ? dvs_abs : {1'b0, divisor};
         prem_q    <= '0;
         cnt_q     <= '0;
         neg_dvd_q <= dividend[31];
         neg_quo_q <= dividend[31] ^ divisor[15];
         zdiv_q    <= (divisor == 16'd0);
      end else if (iter) begin
         // Dividend register doubles as the quotient shift register.
         dvd_q  <= {dvd_q[30:0], ge};
         prem_q <= prem_nxt;
         cnt_q  <= cnt_q + 6'd1;
      end else if (fin) begin
         quot_q <= quot_fin;
         ovf_q  <= sat_fin;
         dbz_q  <= zdiv_q;
      end
   end

   assign quotient = quot_q;
   assign ovf      = ovf_q;
   assign dbz      = dbz_q;

`ifdef FINE_CHANNELIZER_DIV_REM_EN
   logic [15:0] rem_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rem_q <= '0;
      end else if (fin) begin
         if (zdiv_q)         rem_q <= '0;
         else if (neg_dvd_q) rem_q <= 16'd0 - prem_q[15:0];
         else                rem_q <= prem_q[15:0];
      end
   end

   assign remainder = rem_q;
`else
   assign remainder = '0;
`endif

endmodule

// File: tb/tb_fine_channelizer_div_seq.sv
// Directed self-checking bench for fine_channelizer_div_seq (both remainder build options).
module tb_fine_channelizer_div_seq;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        ce = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] dividend = '0;
   logic [15:0] divisor = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [15:0] quotient;
   logic [15:0] remainder;
   logic        ovf;
   logic        dbz;
   logic [1:0]  dbg_state;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   logic [15:0] exp_q[$];

`ifdef FINE_CHANNELIZER_DIV_REM_EN
   localparam bit REM_EN = 1'b1;
`else
   localparam bit REM_EN = 1'b0;
`endif

   fine_channelizer_div_seq dut (
      .clk(clk), .reset_n(reset_n), .ce(ce),
      .in_valid(in_valid), .in_ready(in_ready),
      .dividend(dividend), .divisor(divisor),
      .out_valid(out_valid), .out_ready(out_ready),
      .quotient(quotient), .remainder(remainder),
      .ovf(ovf), .dbz(dbz), .dbg_state(dbg_state)
   );

   // ---------------- clock / cycle counter ----------------
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [15:0] xr(input logic [15:0] r);
      return REM_EN ? r : 16'd0;
   endfunction

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send_pair(input logic [31:0] a, input logic [15:0] b, output int acc);
      int w = 0;
      while (!in_ready && w < 100) begin step(); w++; end
      if (!in_ready) begin
         checks++; errors++;
         $display("FAIL in_ready_timeout got %0b want 1", in_ready);
      end
      in_valid = 1'b1; dividend = a; divisor = b;
      step();
      acc = cyc;
      in_valid = 1'b0; dividend = ~a; divisor = ~b;
   endtask

   task automatic wait_result(output int lat);
      lat = 0;
      while (!out_valid && lat < 200) begin step(); lat++; end
      if (!out_valid) begin
         checks++; errors++;
         $display("FAIL out_valid_timeout got %0b want 1", out_valid);
      end
   endtask

   task automatic do_op(input logic [31:0] a, input logic [15:0] b,
                        output logic [33:0] res, output int lat);
      int acc;
      send_pair(a, b, acc);
      wait_result(lat);
      res = {quotient, remainder, ovf, dbz};
      out_ready = 1'b1;
      step();
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({in_ready, out_valid, quotient, remainder, ovf, dbz, dbg_state} !== {1'b1, 1'b0, 34'd0, 2'd0}) begin
         errors++;
         $display("FAIL reset_state got rdy=%b vld=%b q=%h r=%h ovf=%b dbz=%b st=%0d want rdy=1 vld=0 q=0 r=0 ovf=0 dbz=0 st=0",
                  in_ready, out_valid, quotient, remainder, ovf, dbz, dbg_state);
      end
      @(negedge clk) reset_n = 1'b1;
      step();
      checks++;
      if ({in_ready, out_valid} !== 2'b10) begin
         errors++;
         $display("FAIL reset_release got rdy=%b vld=%b want rdy=1 vld=0", in_ready, out_valid);
      end
   endtask

   task automatic test_basic();
      logic [33:0] res;
      int lat;
      do_op(32'd100, 16'd7, res, lat);
      checks++;
      if (res !== {16'd14, xr(16'd2), 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL basic_100_7 got %h want %h", res, {16'd14, xr(16'd2), 1'b0, 1'b0});
      end
      checks++;
      if (lat !== 33) begin
         errors++;
         $display("FAIL basic_latency got %0d want 33", lat);
      end
      checks++;
      if ({out_valid, in_ready} !== 2'b01) begin
         errors++;
         $display("FAIL basic_drain got vld=%b rdy=%b want vld=0 rdy=1", out_valid, in_ready);
      end
   endtask

   task automatic test_signs();
      logic [33:0] res;
      int lat;
      do_op(-32'sd100, 16'd7, res, lat);
      checks++;
      if (res !== {-16'sd14, xr(-16'sd2), 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL sign_m100_7 got %h want %h", res, {-16'sd14, xr(-16'sd2), 1'b0, 1'b0});
      end
      do_op(32'd100, -16'sd7, res, lat);
      checks++;
      if (res !== {-16'sd14, xr(16'd2), 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL sign_100_m7 got %h want %h", res, {-16'sd14, xr(16'd2), 1'b0, 1'b0});
      end
      do_op(-32'sd100, -16'sd7, res, lat);
      checks++;
      if (res !== {16'd14, xr(-16'sd2), 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL sign_m100_m7 got %h want %h", res, {16'd14, xr(-16'sd2), 1'b0, 1'b0});
      end
   endtask

   task automatic test_saturation();
      logic [33:0] res;
      int lat;
      do_op(32'h7FFF_FFFF, 16'd1, res, lat);
      checks++;
      if (res !== {16'h7FFF, 16'd0, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL sat_max_1 got %h want %h", res, {16'h7FFF, 16'd0, 1'b1, 1'b0});
      end
      do_op(32'h8000_0000, 16'h8000, res, lat);
      checks++;
      if (res !== {16'h7FFF, 16'd0, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL sat_min_min got %h want %h", res, {16'h7FFF, 16'd0, 1'b1, 1'b0});
      end
      do_op(32'hFFF0_0000, 16'd32, res, lat);
      checks++;
      if (res !== {16'h8000, 16'd0, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL sat_exact_min got %h want %h", res, {16'h8000, 16'd0, 1'b0, 1'b0});
      end
      do_op(32'd65534, 16'd2, res, lat);
      checks++;
      if (res !== {16'h7FFF, 16'd0, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL sat_exact_max got %h want %h", res, {16'h7FFF, 16'd0, 1'b0, 1'b0});
      end
   endtask

   task automatic test_dbz();
      logic [33:0] res;
      int lat;
      do_op(32'd5, 16'd0, res, lat);
      checks++;
      if (res !== {16'h7FFF, 16'd0, 1'b0, 1'b1}) begin
         errors++;
         $display("FAIL dbz_pos got %h want %h", res, {16'h7FFF, 16'd0, 1'b0, 1'b1});
      end
      checks++;
      if (lat !== 33) begin
         errors++;
         $display("FAIL dbz_latency got %0d want 33", lat);
      end
      do_op(-32'sd5, 16'd0, res, lat);
      checks++;
      if (res !== {16'h8000, 16'd0, 1'b0, 1'b1}) begin
         errors++;
         $display("FAIL dbz_neg got %h want %h", res, {16'h8000, 16'd0, 1'b0, 1'b1});
      end
   endtask

   task automatic test_backpressure();
      logic [33:0] res;
      int acc, lat;
      out_ready = 1'b0;
      send_pair(-32'sd100, 16'd7, acc);
      wait_result(lat);
      for (int i = 0; i < 10; i++) begin
         in_valid = 1'b1; dividend = 32'd999; divisor = 16'd3;
         step();
         checks++;
         if ({out_valid, in_ready, quotient, remainder, dbg_state} !== {2'b10, -16'sd14, xr(-16'sd2), 2'd2}) begin
            errors++;
            $display("FAIL backpressure_hold cycle %0d got vld=%b rdy=%b q=%h r=%h st=%0d want vld=1 rdy=0 q=fff2 r=%h st=2",
                     i, out_valid, in_ready, quotient, remainder, dbg_state, xr(-16'sd2));
         end
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      step();
      checks++;
      if ({out_valid, in_ready} !== 2'b01) begin
         errors++;
         $display("FAIL backpressure_release got vld=%b rdy=%b want vld=0 rdy=1", out_valid, in_ready);
      end
      do_op(32'd100, 16'd7, res, lat);
      checks++;
      if (res !== {16'd14, xr(16'd2), 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL backpressure_next got %h want %h", res, {16'd14, xr(16'd2), 1'b0, 1'b0});
      end
   endtask

   task automatic test_ce_stall();
      int acc, lat;
      send_pair(32'd1000, 16'd9, acc);
      lat = 0;
      while (!out_valid && lat < 200) begin
         ce = (lat >= 10 && lat < 13) ? 1'b0 : 1'b1;
         step();
         lat++;
      end
      ce = 1'b1;
      checks++;
      if (lat !== 36) begin
         errors++;
         $display("FAIL ce_latency got %0d want 36", lat);
      end
      checks++;
      if ({quotient, remainder} !== {16'd111, xr(16'd1)}) begin
         errors++;
         $display("FAIL ce_result got q=%0d r=%0d want q=111 r=%0d", quotient, remainder, xr(16'd1));
      end
      ce = 1'b0;
      step();
      checks++;
      if (out_valid !== 1'b1) begin
         errors++;
         $display("FAIL ce_low_no_handshake got vld=%b want 1", out_valid);
      end
      ce = 1'b1;
      step();
   endtask

   task automatic test_back_to_back();
      int acc1, acc2, lat;
      exp_q.push_back(16'd14);
      exp_q.push_back(-16'sd14);
      send_pair(32'd100, 16'd7, acc1);
      wait_result(lat);
      checks++;
      if (quotient !== exp_q.pop_front()) begin
         errors++;
         $display("FAIL b2b_first got %h want 000e", quotient);
      end
      step();
      send_pair(-32'sd100, 16'd7, acc2);
      checks++;
      if (acc2 - acc1 !== 35) begin
         errors++;
         $display("FAIL b2b_spacing got %0d want 35", acc2 - acc1);
      end
      wait_result(lat);
      checks++;
      if (quotient !== exp_q.pop_front()) begin
         errors++;
         $display("FAIL b2b_second got %h want fff2", quotient);
      end
      step();
   endtask

   task automatic test_reset_calc();
      logic [33:0] res;
      int acc, lat;
      bit seen;
      send_pair(32'd100, 16'd7, acc);
      repeat (12) step();
      reset_n = 1'b0;
      #1;
      checks++;
      if ({in_ready, out_valid, quotient, remainder, ovf, dbz, dbg_state} !== {1'b1, 1'b0, 34'd0, 2'd0}) begin
         errors++;
         $display("FAIL reset_calc_state got rdy=%b vld=%b q=%h r=%h ovf=%b dbz=%b st=%0d want rdy=1 vld=0 q=0 r=0 ovf=0 dbz=0 st=0",
                  in_ready, out_valid, quotient, remainder, ovf, dbz, dbg_state);
      end
      @(negedge clk) reset_n = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 50; i++) begin
         step();
         if (out_valid) seen = 1'b1;
      end
      checks++;
      if (seen !== 1'b0) begin
         errors++;
         $display("FAIL reset_calc_no_output got %b want 0", seen);
      end
      do_op(32'd100, 16'd7, res, lat);
      checks++;
      if (res !== {16'd14, xr(16'd2), 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL reset_calc_next got %h want %h", res, {16'd14, xr(16'd2), 1'b0, 1'b0});
      end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      test_reset();
      test_basic();
      test_signs();
      test_saturation();
      test_dbz();
      test_backpressure();
      test_ce_stall();
      test_back_to_back();
      test_reset_calc();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fine_channelizer_div_seq.md
# fine_channelizer_div_seq

Sequential signed divider, the inverse operation of the channelizer's pipelined 16x16 signed multiplier. It divides a 32-bit signed product-domain value by a 16-bit signed divisor and returns a saturated 16-bit signed quotient plus a remainder. It sits after the fine-channel gain/normalisation stage and undoes a gain product back into sample width. It uses one iterative restoring-division datapath with valid/ready handshakes on both sides.

## Interface
- DIVIDEND_WIDTH, 32, signed dividend width; fixed at 32.
- DIVISOR_WIDTH, 16, signed divisor width; fixed at 16.
- QUOTIENT_WIDTH, 16, signed quotient and remainder width; fixed at 16.

- clk  in  1  rising-edge clock; the only clock.
- reset_n  in  1  asynchronous, active-low reset.
- ce  in  1  clock enable. When low, all state, counters and outputs hold, and no handshake completes.
- in_valid  in  1  dividend/divisor pair valid.
- in_ready  out  1  block can accept a pair.
- dividend  in  32  signed dividend.
- divisor  in  16  signed divisor.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- quotient  out  16  signed quotient, truncated toward zero, saturated.
- remainder  out  16  signed remainder; its sign follows the dividend.
- ovf  out  1  quotient was saturated; excludes the divide-by-zero case.
- dbz  out  1  divisor was zero.

## Operation
- States: IDLE, CALC, DONE.
- in_ready = (state == IDLE).
- IDLE to CALC on ce & in_valid & in_ready. This step:
  - registers |dividend| (32-bit unsigned; -2^31 maps to 2^31) and |divisor| (17-bit unsigned);
  - registers the sign of the dividend and the sign of the quotient (XOR of the two input signs);
  - clears the 32-bit partial remainder and the iteration counter.
- CALC performs one restoring step per ce cycle over 32 iterations, MSB first:
  - shift {partial remainder, dividend bit} left;
  - if the result is ≥ |divisor|, subtract and shift in quotient bit 1, else shift in 0.
- After iteration 32, a finalisation cycle registers the outputs and the state moves to DONE:
  - negate the quotient and remainder according to the stored signs;
  - saturate the quotient to [-32768, 32767] and set ovf if clamping occurred. A quotient of exactly -32768 is legal and does not set ovf.
  - The remainder magnitude is always less than 32768, so it never saturates.
- Divisor zero:
  - quotient = 32767 if dividend ≥ 0, else -32768;
  - remainder = 0, dbz = 1, ovf = 0;
  - the block still takes the full latency.
- DONE holds out_valid and all result outputs stable until ce & out_ready, then moves to IDLE. out_valid drops and in_ready rises on the next cycle.
- No input is accepted while a result is pending; there is no overlap between operations.

## Timing
- Reset (asynchronous, takes effect immediately):
  - state = IDLE, in_ready = 1, out_valid = 0;
  - quotient = 0, remainder = 0, ovf = 0, dbz = 0;
  - the counter is cleared.
- Reset asserted during CALC or DONE discards the operation; nothing is emitted after release.
- Latency with ce held high:
  - input handshake at edge 0;
  - iterations at edges 1–32;
  - finalisation at edge 33;
  - out_valid is high after edge 33.
- Throughput: at most one result per 35 cycles (accept, 32 iterations, finalise, 1 cycle in DONE if out_ready is already high).
- A ce low cycle stretches the latency by exactly one cycle per low cycle at any point.
- out_valid never deasserts without a completed output handshake (except reset).
- dividend and divisor are sampled only at the input handshake edge; later input changes are ignored.

## Configuration
- FINE_CHANNELIZER_DIV_REM_EN defined:
  - the remainder output is computed and registered as described.
- FINE_CHANNELIZER_DIV_REM_EN not defined:
  - the remainder sign-fix and output register are removed;
  - the remainder port is driven constant 0;
  - quotient, flags and latency are unchanged.

## Test plan
- 100 / 7, out_ready held high → quotient 14, remainder 2, ovf 0, dbz 0; out_valid rises 33 cycles after the accept.
- -100 / 7 → quotient -14, remainder -2; and 100 / -7 → quotient -14, remainder 2.
- Saturation cases:
  - 2147483647 / 1 → quotient 32767, ovf 1;
  - -2147483648 / -32768 → quotient 32767, ovf 1;
  - -1048576 / 32 → quotient -32768, ovf 0.
- Divide by zero: 5 / 0 → quotient 32767, remainder 0, dbz 1; -5 / 0 → quotient -32768, dbz 1.
- Back-pressure and ce:
  - hold out_ready low for 10 cycles → result stable, in_ready 0;
  - toggle ce low for 3 cycles mid-CALC → out_valid delayed by exactly 3 cycles.
- Reset in CALC: pulse reset_n low at iteration 12 → outputs return to reset values immediately, no out_valid afterwards, and the next input 100 / 7 gives 14 / 2.
